// File: rtl/adc_align_ctrl.sv
// Bitslip alignment sequencer for one 6-bit ADC deserializer lane.
// Optional loss-of-lock monitor enabled by defining ADC_ALIGN_MONITOR_EN.
module adc_align_ctrl #(
   parameter logic [5:0]  PATTERN    = 6'b111000,
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned SETTLE     = 8,
   parameter int unsigned SLIP_WAIT  = 4,
   parameter int unsigned MATCH_CNT  = 16,
   parameter int unsigned MAX_SLIPS  = 12,
   parameter int unsigned LOSS_CNT   = 4
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       start,
   input  logic [5:0] din,
   output logic       serdes_rst,
   output logic       bs,
   output logic       busy,
   output logic       locked,
   output logic       fail,
   output logic [3:0] slips,
   output logic [7:0] err_cnt
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StRst    = 3'd1;
   localparam logic [2:0] StSettle = 3'd2;
   localparam logic [2:0] StCheck  = 3'd3;
   localparam logic [2:0] StSlip   = 3'd4;
   localparam logic [2:0] StWait   = 3'd5;
   localparam logic [2:0] StLocked = 3'd6;
   localparam logic [2:0] StFail   = 3'd7;

   localparam logic [7:0] RstLast   = 8'(RST_CYCLES - 1);
   localparam logic [7:0] SettLast  = 8'(SETTLE - 1);
   localparam logic [7:0] WaitLast  = 8'(SLIP_WAIT - 1);
   localparam logic [7:0] MatchLast = 8'(MATCH_CNT - 1);
   localparam logic [3:0] MaxSlips  = 4'(MAX_SLIPS);

   logic [2:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] slips_q, slips_d;
   logic [7:0] err_q, err_d;
   logic       serdes_rst_q, bs_q, busy_q, locked_q, fail_q;
`ifdef ADC_ALIGN_MONITOR_EN
   localparam logic [7:0] LossLast = 8'(LOSS_CNT - 1);
   logic [7:0] loss_q, loss_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      slips_d = slips_q;
      err_d   = err_q;
`ifdef ADC_ALIGN_MONITOR_EN
      loss_d  = loss_q;
`endif
      case (state_q)
         StIdle, StLocked, StFail: begin
            if (start) begin
               state_d = StRst;
               cnt_d   = '0;
               slips_d = '0;
               err_d   = '0;
`ifdef ADC_ALIGN_MONITOR_EN
               loss_d  = '0;
`endif
            end else if (state_q == StLocked) begin
               if (din != PATTERN) begin
                  if (err_q != 8'hff) err_d = err_q + 8'd1;
`ifdef ADC_ALIGN_MONITOR_EN
                  // Sustained loss of lock: restart alignment, keep the error history.
                  if (loss_q == LossLast) begin
                     state_d = StRst;
                     cnt_d   = '0;
                     slips_d = '0;
                     loss_d  = '0;
                  end else begin
                     loss_d = loss_q + 8'd1;
                  end
               end else begin
                  loss_d = '0;
`endif
               end
            end
         end
         StRst: begin
            if (cnt_q == RstLast) begin
               state_d = StSettle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StSettle: begin
            if (cnt_q == SettLast) begin
               state_d = StCheck;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StCheck: begin
            if (din == PATTERN) begin
               if (cnt_q == MatchLast) state_d = StLocked;
               else                    cnt_d   = cnt_q + 8'd1;
            end else if (slips_q < MaxSlips) begin
               state_d = StSlip;
               slips_d = slips_q + 4'd1;
            end else begin
               state_d = StFail;
            end
         end
         StSlip: begin
            state_d = StWait;
            cnt_d   = '0;
         end
         StWait: begin
            if (cnt_q == WaitLast) begin
               state_d = StCheck;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         slips_q      <= '0;
         err_q        <= '0;
         serdes_rst_q <= 1'b0;
         bs_q         <= 1'b0;
         busy_q       <= 1'b0;
         locked_q     <= 1'b0;
         fail_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         slips_q      <= slips_d;
         err_q        <= err_d;
         // Flags decode the next state so they line up with the state register.
         serdes_rst_q <= (state_d == StRst);
         bs_q         <= (state_d == StSlip);
         busy_q       <= (state_d == StRst) || (state_d == StSettle) || (state_d == StCheck) ||
                         (state_d == StSlip) || (state_d == StWait);
         locked_q     <= (state_d == StLocked);
         fail_q       <= (state_d == StFail);
      end
   end

`ifdef ADC_ALIGN_MONITOR_EN
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) loss_q <= '0;
      else          loss_q <= loss_d;
   end
`endif

   assign serdes_rst = serdes_rst_q;
   assign bs         = bs_q;
   assign busy       = busy_q;
   assign locked     = locked_q;
   assign fail       = fail_q;
   assign slips      = slips_q;
   assign err_cnt    = err_q;

endmodule

// File: doc/adc_align_ctrl.md
# adc_align_ctrl

Bitslip alignment sequencer for one 6-bit ADC deserializer lane. It resets the ISERDES2 master/slave pair and watches the deserialized word. It then issues single-cycle bitslip pulses until the word equals a known training pattern (the ADC frame pattern) for a run of consecutive cycles, and reports lock, failure and slip count. It sits in the CLK (CLKDIV) domain next to each lane receiver and drives that receiver's BS and reset inputs.

## Interface
Parameters:
- PATTERN, 6'b111000, expected aligned word during training.
- RST_CYCLES, 4, cycles serdes_rst is held high.
- SETTLE, 8, cycles waited after serdes_rst release before checking.
- SLIP_WAIT, 4, cycles ignored after each bs pulse (ISERDES2 pipeline).
- MATCH_CNT, 16, consecutive matches required for lock (1..255).
- MAX_SLIPS, 12, slips tried before failure (2×DATA_WIDTH covers all positions).
- LOSS_CNT, 4, consecutive mismatches in LOCKED that declare loss of lock (monitor only).

Ports:
- CLK, input, 1: fabric clock; the same CLK that drives the deserializer CLKDIV.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: level-sampled request to (re)align.
- din, input, 6: deserialized word from the lane receiver.
- serdes_rst, output, 1: reset to the lane receiver, active-high.
- bs, output, 1: bitslip pulse to the lane receiver.
- busy, output, 1: alignment in progress.
- locked, output, 1: lane aligned.
- fail, output, 1: alignment failed.
- slips, output, 4: number of bitslips issued in the current attempt.
- err_cnt, output, 8: mismatches counted while LOCKED; saturates at 255.

## Operation
- States: IDLE, RST, SETTLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
- IDLE, LOCKED and FAIL accept start=1.
  - On start, go to RST.
  - Clear slips and err_cnt, and clear locked and fail.
- start is ignored in RST, SETTLE, CHECK, SLIP and WAIT.
- RST: serdes_rst=1 for RST_CYCLES cycles, then SETTLE.
- SETTLE: wait SETTLE cycles, then CHECK with the match counter cleared.
- CHECK: compare din with PATTERN every cycle.
  - On a match, increment the match counter. When it reaches MATCH_CNT, go to LOCKED.
  - On a mismatch with slips < MAX_SLIPS, go to SLIP.
  - On a mismatch with slips == MAX_SLIPS, go to FAIL.
- SLIP: bs=1 for exactly one cycle and increment slips, then WAIT.
- WAIT: hold SLIP_WAIT cycles with din ignored, then CHECK with the match counter cleared.
- LOCKED: locked=1. Every din != PATTERN increments err_cnt (saturating).
- FAIL: fail=1 and serdes_rst=0. Remain until start.
- busy=1 in RST, SETTLE, CHECK, SLIP and WAIT; busy=0 otherwise.
- bs and serdes_rst are never high in the same cycle.

## Timing
- Reset state: every output is 0 (serdes_rst, bs, busy, locked, fail, slips, err_cnt); the state is IDLE.
- Reset is asynchronous and may arrive mid-sequence. Deassertion of reset_n returns to IDLE; an in-flight bs pulse is truncated.
- All outputs are registered.
- Start timeline, with start sampled high at cycle 0 and default parameters:
  - serdes_rst is high in cycles 1..4.
  - SETTLE covers cycles 5..12.
  - The first CHECK cycle is cycle 13.
- Lock latency:
  - An already aligned lane asserts locked at cycle 29.
  - Each misaligned position mismatches on its first CHECK cycle and costs 6 cycles (CHECK, SLIP, 4×WAIT). Lock is then at cycle 29+6k for k slips.
- Failure timing: with no position matching, fail is asserted at cycle 13+6×12+1 = 86 and slips reads 12.
- A single mismatch after partial matches in CHECK triggers a slip; the match count does not carry over.
- locked falls in the same cycle that busy rises on a re-align.

## Configuration
- Macro: ADC_ALIGN_MONITOR_EN.
- Defined:
  - In LOCKED, LOSS_CNT consecutive mismatches clear locked and re-enter RST automatically.
  - slips is cleared and err_cnt is retained.
  - Any match resets the loss counter.
- Undefined:
  - LOCKED is sticky until start or reset.
  - Mismatches only increment err_cnt.

## Test plan
- Reset values:
  - Stimulus: reset_n low with random din and start.
  - Required: all outputs 0; after release, outputs stay 0 while start=0.
- Aligned lane:
  - Stimulus: din=6'b111000 constantly; start pulse at cycle 0.
  - Required: serdes_rst high in cycles 1..4, no bs, locked=1 at cycle 29, slips=0.
- Rotated lane:
  - Stimulus: din model advances one bit per bs pulse, starting 3 positions off.
  - Required: exactly 3 one-cycle bs pulses, locked at cycle 47, slips=3.
- Unalignable lane:
  - Stimulus: din=6'b000000.
  - Required: 12 bs pulses, fail=1 at cycle 86, locked=0, busy=0.
- Busy and mid-sequence reset:
  - Stimulus: start re-pulsed during CHECK, then reset_n pulsed low during WAIT.
  - Required: the second start has no effect; after reset, all outputs are 0 and the state is IDLE.
- Monitor:
  - Stimulus: after lock, inject 3 mismatches, then 1 match, then 4 mismatches.
  - Required: err_cnt=7.
  - With ADC_ALIGN_MONITOR_EN: re-alignment starts after the 4th consecutive mismatch, so serdes_rst rises and locked falls.
  - Without ADC_ALIGN_MONITOR_EN: locked stays 1.
